// File: rtl/sccb_config_sequencer.sv
// Camera register-table sequencer: walks a {addr,data} ROM and issues one SCCB write per entry.
// Build macro SCCB_RETRY_EN adds bounded per-entry retries on NACK.
// IDLE waiting start | POWERUP power-up wait | FETCH ROM latency | DECODE entry | ISSUE request
// WAIT_DONE bus write | DELAY delay entry | DONE table complete | ERROR write failed
module sccb_config_sequencer #(
   parameter int p_rom_addrw   = 8,
   parameter int p_rom_latency = 1,
   parameter int p_clk_hz      = 25_000_000,
   parameter int p_powerup_ms  = 1,
   parameter int p_delay_ms    = 10,
   parameter int p_max_retries = 3
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_start,
   output logic [p_rom_addrw-1:0] o_rom_addr,
   input  logic [15:0]            i_rom_data,
   output logic                   o_sccb_valid,
   input  logic                   i_sccb_ready,
   output logic [7:0]             o_sccb_addr,
   output logic [7:0]             o_sccb_data,
   input  logic                   i_sccb_done,
   input  logic                   i_sccb_nack,
   output logic                   o_busy,
   output logic                   o_done,
   output logic                   o_error,
   output logic [p_rom_addrw-1:0] o_err_addr,
   output logic [p_rom_addrw:0]   o_wr_count
);

   localparam int lp_pu_cyc   = p_powerup_ms * p_clk_hz / 1000;
   localparam int lp_dly_cyc  = p_delay_ms * p_clk_hz / 1000;
   localparam int lp_cnt_max0 = (lp_pu_cyc > lp_dly_cyc) ? lp_pu_cyc : lp_dly_cyc;
   localparam int lp_cnt_max  = (lp_cnt_max0 > p_rom_latency) ? lp_cnt_max0 : p_rom_latency;
   localparam int lp_cntw     = $clog2(lp_cnt_max) + 1;

   // A wait of zero cycles still spends one cycle in its state.
   localparam logic [lp_cntw-1:0] lp_pu_load    = (lp_pu_cyc > 0)  ? lp_cntw'(lp_pu_cyc - 1)  : '0;
   localparam logic [lp_cntw-1:0] lp_dly_load   = (lp_dly_cyc > 0) ? lp_cntw'(lp_dly_cyc - 1) : '0;
   localparam logic [lp_cntw-1:0] lp_fetch_load = lp_cntw'(p_rom_latency - 1);

`ifdef SCCB_RETRY_EN
   localparam int                 lp_rtw       = (p_max_retries > 0) ? $clog2(p_max_retries + 1) : 1;
   localparam logic [lp_rtw-1:0]  lp_retry_max = lp_rtw'(p_max_retries);
`else
   localparam int lp_unused_max_retries = p_max_retries;
`endif

   typedef enum logic [3:0] {
      S_IDLE,
      S_POWERUP,
      S_FETCH,
      S_DECODE,
      S_ISSUE,
      S_WAIT_DONE,
      S_DELAY,
      S_DONE,
      S_ERROR
   } state_t;

   state_t                 state_q,     state_d;
   logic [lp_cntw-1:0]     cnt_q,       cnt_d;
   logic [p_rom_addrw-1:0] rom_addr_q,  rom_addr_d;
   logic                   valid_q,     valid_d;
   logic [7:0]             sccb_addr_q, sccb_addr_d;
   logic [7:0]             sccb_data_q, sccb_data_d;
   logic                   done_q,      done_d;
   logic                   error_q,     error_d;
   logic [p_rom_addrw-1:0] err_addr_q,  err_addr_d;
   logic [p_rom_addrw:0]   wr_count_q,  wr_count_d;
   logic                   autostart_q, autostart_d;
   logic                   advance;
`ifdef SCCB_RETRY_EN
   logic [lp_rtw-1:0]      retry_q,     retry_d;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         rom_addr_q  <= '0;
         valid_q     <= 1'b0;
         sccb_addr_q <= '0;
         sccb_data_q <= '0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         err_addr_q  <= '0;
         wr_count_q  <= '0;
         autostart_q <= 1'b1;
`ifdef SCCB_RETRY_EN
         retry_q     <= '0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rom_addr_q  <= rom_addr_d;
         valid_q     <= valid_d;
         sccb_addr_q <= sccb_addr_d;
         sccb_data_q <= sccb_data_d;
         done_q      <= done_d;
         error_q     <= error_d;
         err_addr_q  <= err_addr_d;
         wr_count_q  <= wr_count_d;
         autostart_q <= autostart_d;
`ifdef SCCB_RETRY_EN
         retry_q     <= retry_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rom_addr_d  = rom_addr_q;
      valid_d     = valid_q;
      sccb_addr_d = sccb_addr_q;
      sccb_data_d = sccb_data_q;
      done_d      = done_q;
      error_d     = error_q;
      err_addr_d  = err_addr_q;
      wr_count_d  = wr_count_q;
      autostart_d = autostart_q;
      advance     = 1'b0;
`ifdef SCCB_RETRY_EN
      retry_d     = retry_q;
`endif

      case (state_q)
         // The post-reset run is an implicit start request taken from IDLE.
         S_IDLE, S_DONE, S_ERROR: begin
            if (i_start || autostart_q) begin
               state_d     = S_POWERUP;
               cnt_d       = lp_pu_load;
               rom_addr_d  = '0;
               done_d      = 1'b0;
               error_d     = 1'b0;
               err_addr_d  = '0;
               wr_count_d  = '0;
               autostart_d = 1'b0;
`ifdef SCCB_RETRY_EN
               retry_d     = '0;
`endif
            end
         end
         S_POWERUP: begin
            if (cnt_q == '0) begin
               state_d = S_FETCH;
               cnt_d   = lp_fetch_load;
            end else begin
               cnt_d = cnt_q - lp_cntw'(1);
            end
         end
         S_FETCH: begin
            if (cnt_q == '0) begin
               state_d = S_DECODE;
            end else begin
               cnt_d = cnt_q - lp_cntw'(1);
            end
         end
         S_DECODE: begin
            if (i_rom_data == 16'hFFFF) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end else if (i_rom_data == 16'hFFF0) begin
               state_d = S_DELAY;
               cnt_d   = lp_dly_load;
            end else begin
               state_d     = S_ISSUE;
               sccb_addr_d = i_rom_data[15:8];
               sccb_data_d = i_rom_data[7:0];
               valid_d     = 1'b1;
            end
         end
         S_ISSUE: begin
            if (i_sccb_ready) begin
               state_d = S_WAIT_DONE;
               valid_d = 1'b0;
            end
         end
         S_WAIT_DONE: begin
            if (i_sccb_done) begin
               if (!i_sccb_nack) begin
                  wr_count_d = wr_count_q + (p_rom_addrw + 1)'(1);
                  advance    = 1'b1;
`ifdef SCCB_RETRY_EN
               end else if (retry_q < lp_retry_max) begin
                  retry_d = retry_q + lp_rtw'(1);
                  valid_d = 1'b1;
                  state_d = S_ISSUE;
`endif
               end else begin
                  state_d    = S_ERROR;
                  error_d    = 1'b1;
                  err_addr_d = rom_addr_q;
               end
            end
         end
         S_DELAY: begin
            if (cnt_q == '0) begin
               advance = 1'b1;
            end else begin
               cnt_d = cnt_q - lp_cntw'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      // The last table slot ends the run rather than wrapping to entry 0.
      if (advance) begin
         if (rom_addr_q == '1) begin
            state_d = S_DONE;
            done_d  = 1'b1;
         end else begin
            state_d    = S_FETCH;
            cnt_d      = lp_fetch_load;
            rom_addr_d = rom_addr_q + p_rom_addrw'(1);
`ifdef SCCB_RETRY_EN
            retry_d    = '0;
`endif
         end
      end
   end

   assign o_rom_addr   = rom_addr_q;
   assign o_sccb_valid = valid_q;
   assign o_sccb_addr  = sccb_addr_q;
   assign o_sccb_data  = sccb_data_q;
   assign o_busy       = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERROR);
   assign o_done       = done_q;
   assign o_error      = error_q;
   assign o_err_addr   = err_addr_q;
   assign o_wr_count   = wr_count_q;

endmodule

// File: tb/tb_sccb_config_sequencer.sv
// Bench for sccb_config_sequencer: ROM and SCCB master models, table vectors, directed corners, random tables.
module tb_sccb_config_sequencer;

   localparam int lp_aw    = 4;
   localparam int lp_depth = 16;
`ifdef SCCB_RETRY_EN
   localparam int lp_maxr  = 3;
   localparam bit lp_retry = 1'b1;
`else
   localparam int lp_maxr  = 0;
   localparam bit lp_retry = 1'b0;
`endif
   // power-up 2 cycles + ROM latency 1 + decode 1, counted from the accepting edge inclusive
   localparam int lp_first_valid = 2 + 1 + 2;

   logic             i_clk;
   logic             i_rst;
   logic             i_start;
   logic [lp_aw-1:0] o_rom_addr;
   logic [15:0]      rom_q;
   logic             o_sccb_valid;
   logic             sccb_ready;
   logic [7:0]       o_sccb_addr;
   logic [7:0]       o_sccb_data;
   logic             sccb_done;
   logic             sccb_nack;
   logic             o_busy;
   logic             o_done;
   logic             o_error;
   logic [lp_aw-1:0] o_err_addr;
   logic [lp_aw:0]   o_wr_count;

   sccb_config_sequencer #(
      .p_rom_addrw   (lp_aw),
      .p_rom_latency (1),
      .p_clk_hz      (1000),
      .p_powerup_ms  (2),
      .p_delay_ms    (3),
      .p_max_retries (3)
   ) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_start      (i_start),
      .o_rom_addr   (o_rom_addr),
      .i_rom_data   (rom_q),
      .o_sccb_valid (o_sccb_valid),
      .i_sccb_ready (sccb_ready),
      .o_sccb_addr  (o_sccb_addr),
      .o_sccb_data  (o_sccb_data),
      .i_sccb_done  (sccb_done),
      .i_sccb_nack  (sccb_nack),
      .o_busy       (o_busy),
      .o_done       (o_done),
      .o_error      (o_error),
      .o_err_addr   (o_err_addr),
      .o_wr_count   (o_wr_count)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   logic [15:0] rom [lp_depth];
   int          nack_plan [lp_depth];
   int          plan_gen;
   logic [15:0] got_log [$];
   logic [15:0] exp_log [$];
   int          n_tests;
   int          n_fail;
   int          hold1;
   bit          rnd_ready;

   always @(posedge i_clk) rom_q <= rom[o_rom_addr];

   // SCCB master: logs each accepted write, answers done four cycles later, NACKs per plan
   int nack_used [lp_depth];
   int seen_gen;
   int cd;
   always @(posedge i_clk) begin
      if (seen_gen != plan_gen) begin
         seen_gen <= plan_gen;
         for (int k = 0; k < lp_depth; k++) nack_used[k] <= 0;
      end
      if (i_rst) begin
         cd        <= 0;
         sccb_done <= 1'b0;
         sccb_nack <= 1'b0;
      end else begin
         sccb_done <= 1'b0;
         sccb_nack <= 1'b0;
         if (o_sccb_valid && sccb_ready) begin
            got_log.push_back({o_sccb_addr, o_sccb_data});
            cd <= 4;
         end else if (cd != 0) begin
            cd <= cd - 1;
            if (cd == 1) begin
               sccb_done <= 1'b1;
               if (nack_used[o_rom_addr] < nack_plan[o_rom_addr]) begin
                  sccb_nack <= 1'b1;
                  nack_used[o_rom_addr] <= nack_used[o_rom_addr] + 1;
               end
            end
         end
      end
   end

   typedef struct {
      logic [15:0] e0, e1, e2, e3, fill;
      int          nack_idx;
      int          nack_n;
      bit          x_done;
      bit          x_err;
      int          x_ea;
      int          x_wc;
      int          x_hold1;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic load_vec(input vec_t v);
      rom[0] = v.e0;
      rom[1] = v.e1;
      rom[2] = v.e2;
      rom[3] = v.e3;
      for (int k = 4; k < lp_depth; k++) rom[k] = v.fill;
      for (int k = 0; k < lp_depth; k++) nack_plan[k] = 0;
      if (v.nack_idx >= 0) nack_plan[v.nack_idx] = v.nack_n;
      plan_gen++;
   endtask

   // Reference: walk the table entry by entry, expanding NACKs into repeated writes.
   task automatic model_run(output bit xd, output bit xe, output int xea, output int xwc);
      int idx;
      int tries;
      int left;
      bit fin;
      exp_log.delete();
      xd = 0; xe = 0; xea = 0; xwc = 0; idx = 0; fin = 0;
      while (!fin) begin
         if (rom[idx] == 16'hFFFF) begin
            xd = 1; fin = 1;
         end else begin
            if (rom[idx] != 16'hFFF0) begin
               left  = nack_plan[idx];
               tries = 0;
               while (1) begin
                  exp_log.push_back(rom[idx]);
                  if (left == 0) begin
                     xwc++;
                     break;
                  end
                  left--;
                  if (tries == lp_maxr) begin
                     xe = 1; xea = idx; fin = 1;
                     break;
                  end
                  tries++;
               end
            end
            if (!fin) begin
               if (idx == lp_depth - 1) begin
                  xd = 1; fin = 1;
               end else begin
                  idx++;
               end
            end
         end
      end
   endtask

   task automatic pulse_start();
      @(negedge i_clk);
      i_start = 1'b1;
      @(negedge i_clk);
      i_start = 1'b0;
   endtask

   task automatic first_valid_latency(output int n);
      n = 0;
      for (int c = 0; c < 100; c++) begin
         @(posedge i_clk);
         #1;
         n++;
         if (o_sccb_valid) break;
      end
   endtask

   task automatic wait_end();
      bit ok;
      ok    = 1'b0;
      hold1 = 0;
      for (int c = 0; c < 4000; c++) begin
         @(negedge i_clk);
         if (o_busy && o_rom_addr == 4'd1) hold1++;
         if (rnd_ready) sccb_ready = ($urandom_range(0, 3) != 0);
         if (!o_busy && (o_done || o_error)) begin
            ok = 1'b1;
            break;
         end
      end
      sccb_ready = 1'b1;
      check("terminates", int'(ok), 1);
      repeat (8) @(negedge i_clk);
   endtask

   task automatic check_run(input string tag, input bit xd, input bit xe, input int xea,
                            input int xwc, input int base);
      check({tag, ".done"},     int'(o_done),     int'(xd));
      check({tag, ".error"},    int'(o_error),    int'(xe));
      check({tag, ".err_addr"}, int'(o_err_addr), xea);
      check({tag, ".wr_count"}, int'(o_wr_count), xwc);
      check({tag, ".busy"},     int'(o_busy),     0);
      check({tag, ".n_writes"}, got_log.size() - base, exp_log.size());
      for (int k = 0; k < exp_log.size(); k++)
         if (base + k < got_log.size())
            check($sformatf("%s.write%0d", tag, k), int'(got_log[base + k]), int'(exp_log[k]));
   endtask

   initial begin
      bit mxd, mxe;
      int mxea, mxwc, base, lat;
      bit found;
      logic [15:0] w;

      n_tests = 0; n_fail = 0; plan_gen = 0; seen_gen = 0; rnd_ready = 1'b0;
      i_rst = 1'b1; i_start = 1'b0; sccb_ready = 1'b1;

      vecs[0] = '{16'h1280, 16'h1204, 16'hFFFF, 16'hFFFF, 16'hFFFF, -1, 0, 1'b1, 1'b0, 0, 2, -1};
      vecs[1] = '{16'h1101, 16'hFFF0, 16'h3A04, 16'hFFFF, 16'hFFFF, -1, 0, 1'b1, 1'b0, 0, 2, 5};
      vecs[2] = '{16'h1280, 16'h1204, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1, 1,
                  lp_retry, !lp_retry, lp_retry ? 0 : 1, lp_retry ? 2 : 1, -1};
      vecs[3] = '{16'h1280, 16'h1204, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0, 2,
                  lp_retry, !lp_retry, 0, lp_retry ? 2 : 0, -1};
      vecs[4] = '{16'h1280, 16'h1204, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0, 4, 1'b0, 1'b1, 0, 0, -1};
      vecs[5] = '{16'h0100, 16'h0201, 16'h0302, 16'h0403, 16'h5566, -1, 0, 1'b1, 1'b0, 0, 16, -1};
      vecs[6] = '{16'hFFFF, 16'h1280, 16'hFFFF, 16'hFFFF, 16'hFFFF, -1, 0, 1'b1, 1'b0, 0, 0, -1};

      // reset values, then the automatic run on leaving reset
      load_vec(vecs[0]);
      model_run(mxd, mxe, mxea, mxwc);
      repeat (3) @(negedge i_clk);
      check("rst.busy",     int'(o_busy),       0);
      check("rst.done",     int'(o_done),       0);
      check("rst.error",    int'(o_error),      0);
      check("rst.wr_count", int'(o_wr_count),   0);
      check("rst.valid",    int'(o_sccb_valid), 0);
      check("rst.rom_addr", int'(o_rom_addr),   0);
      check("rst.err_addr", int'(o_err_addr),   0);
      base  = got_log.size();
      i_rst = 1'b0;
      first_valid_latency(lat);
      check("autostart.latency", lat, lp_first_valid);
      wait_end();
      check_run("autostart", vecs[0].x_done, vecs[0].x_err, vecs[0].x_ea, vecs[0].x_wc, base);

      for (int i = 0; i < 7; i++) begin
         load_vec(vecs[i]);
         model_run(mxd, mxe, mxea, mxwc);
         base = got_log.size();
         pulse_start();
         check($sformatf("vec%0d.cleared_wc", i),   int'(o_wr_count), 0);
         check($sformatf("vec%0d.cleared_done", i), int'(o_done),     0);
         wait_end();
         if (vecs[i].x_hold1 >= 0) check($sformatf("vec%0d.delay_hold", i), hold1, vecs[i].x_hold1);
         check_run($sformatf("vec%0d", i), vecs[i].x_done, vecs[i].x_err, vecs[i].x_ea, vecs[i].x_wc, base);
      end

      // ready held low for 10 cycles on the first write
      load_vec(vecs[0]);
      model_run(mxd, mxe, mxea, mxwc);
      base       = got_log.size();
      sccb_ready = 1'b0;
      pulse_start();
      found = 1'b0;
      for (int c = 0; c < 50 && !found; c++) begin
         @(negedge i_clk);
         found = o_sccb_valid;
      end
      check("stall.reach_issue", int'(found), 1);
      for (int c = 0; c < 10; c++) begin
         check($sformatf("stall.hold%0d", c), int'({o_sccb_valid, o_sccb_addr, o_sccb_data}), 'h11280);
         @(negedge i_clk);
      end
      sccb_ready = 1'b1;
      wait_end();
      check_run("stall", 1'b1, 1'b0, 0, 2, base);

      // start while busy is ignored
      load_vec(vecs[1]);
      model_run(mxd, mxe, mxea, mxwc);
      base = got_log.size();
      pulse_start();
      repeat (6) @(negedge i_clk);
      i_start = 1'b1;
      @(negedge i_clk);
      i_start = 1'b0;
      wait_end();
      check_run("busy_start", 1'b1, 1'b0, 0, 2, base);

      // reset while the second write waits in ISSUE
      load_vec(vecs[0]);
      model_run(mxd, mxe, mxea, mxwc);
      pulse_start();
      found = 1'b0;
      for (int c = 0; c < 100 && !found; c++) begin
         @(negedge i_clk);
         found = (o_wr_count == 5'd1);
      end
      sccb_ready = 1'b0;
      check("mid_rst.first_write", int'(found), 1);
      found = 1'b0;
      for (int c = 0; c < 50 && !found; c++) begin
         @(negedge i_clk);
         found = o_sccb_valid;
      end
      check("mid_rst.reach_issue", int'(found), 1);
      i_rst = 1'b1;
      @(posedge i_clk);
      #1;
      check("mid_rst.valid",    int'(o_sccb_valid), 0);
      check("mid_rst.busy",     int'(o_busy),       0);
      check("mid_rst.wr_count", int'(o_wr_count),   0);
      check("mid_rst.rom_addr", int'(o_rom_addr),   0);
      @(negedge i_clk);
      i_rst      = 1'b0;
      sccb_ready = 1'b1;
      base       = got_log.size();
      first_valid_latency(lat);
      check("mid_rst.latency", lat, lp_first_valid);
      wait_end();
      check_run("mid_rst", 1'b1, 1'b0, 0, 2, base);

      // random tables, random ready stalls, random NACK plans
      rnd_ready = 1'b1;
      for (int it = 0; it < 30; it++) begin
         for (int k = 0; k < lp_depth; k++) begin
            lat = int'($urandom_range(0, 19));
            if (lat == 0) rom[k] = 16'hFFFF;
            else if (lat < 3) rom[k] = 16'hFFF0;
            else begin
               w = 16'($urandom);
               if (w[15:4] == 12'hFFF) w[15:8] = 8'h42;
               rom[k] = w;
            end
            nack_plan[k] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : 0;
         end
         plan_gen++;
         model_run(mxd, mxe, mxea, mxwc);
         base = got_log.size();
         pulse_start();
         wait_end();
         check_run($sformatf("rnd%0d", it), mxd, mxe, mxea, mxwc, base);
      end
      rnd_ready = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
